// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit with valid/ready streaming on both sides.
// S1 holds {op,a,b}; S2 holds the result, its flags and the completed-handshake counter.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             all_ones,
   output logic             parity,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOTA = 3'd6;

   // Handshake: a beat moves on a rising clk edge when its valid and ready are both high.
   // Ready never depends on the matching valid, so no combinational loop can form.
   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             all_ones_q, all_ones_d;
   logic             parity_q, parity_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             s2_adv;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] s1_result;

   always_comb begin
      s2_adv   = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_adv;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid_q && out_ready;
   end

   always_comb begin
      s1_result = '0;
      case (s1_op_q)
         OP_AND:  s1_result = s1_a_q & s1_b_q;
         OP_OR:   s1_result = s1_a_q | s1_b_q;
         OP_XOR:  s1_result = s1_a_q ^ s1_b_q;
         OP_NAND: s1_result = ~(s1_a_q & s1_b_q);
         OP_NOR:  s1_result = ~(s1_a_q | s1_b_q);
         OP_XNOR: s1_result = ~(s1_a_q ^ s1_b_q);
         OP_NOTA: s1_result = ~s1_a_q;
         default: s1_result = ~s1_b_q;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      // S1 may refill in the same cycle its old beat moves into S2.
      if (in_ready) begin
         s1_valid_d = in_valid;
      end
      if (in_fire) begin
         s1_op_d = op;
         s1_a_d  = a;
         s1_b_d  = b;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      all_ones_d  = all_ones_q;
      parity_d    = parity_q;
      op_count_d  = op_count_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         // Flags are derived from the same value that is registered as result.
         if (s1_valid_q) begin
            result_d   = s1_result;
            zero_d     = (s1_result == '0);
            all_ones_d = &s1_result;
            parity_d   = ^s1_result;
         end
      end
      if (out_fire) begin
         op_count_d = op_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         all_ones_q  <= 1'b0;
         parity_q    <= 1'b0;
         op_count_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         all_ones_q  <= all_ones_d;
         parity_q    <= parity_d;
         op_count_q  <= op_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign all_ones  = all_ones_q;
   assign parity    = parity_q;
   assign op_count  = op_count_q;

endmodule
